spi_txn_sched: RTL and testbench
================================

Name: spi_txn_sched

Overview:
- Two-requester transaction scheduler in front of a byte-level SPI master engine. Targets the 4-register SPI slave, whose protocol uses two SS frames per access.
- Accepts register read/write requests and picks one requester round-robin.
- Sequences each access: SS low, address byte {rw,5'b0,addr}, SS high gap, SS low, data byte, SS high tail. Returns read data or write completion to the winning requester.

Parameters:
- SETUP_CYCLES, 4: clk cycles ss_n is held low before each m_start.
- GAP_CYCLES, 50: clk cycles ss_n is held high between frames and after the data frame. Must be ≥3 for the slave SS synchronisers.
- TIMEOUT_CYCLES, 1024: m_done watchdog limit. Used only with SPI_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  reset; one clock; reset is synchronous and active-low
- req_valid  in  2  request valid, bit i = requester i
- req_wr  in  2  1 = write, 0 = read
- req_addr  in  4  {addr1[1:0], addr0[1:0]}
- req_wdata  in  16  {wdata1, wdata0}
- req_ready  out  2  one-cycle accept pulse to the granted requester
- rsp_valid  out  2  one-cycle completion pulse to the owning requester
- rsp_rdata  out  8  read data; valid with rsp_valid; 8'h00 for writes
- rsp_err  out  1  timeout flag; valid with rsp_valid
- busy  out  1  high whenever state != IDLE
- m_start  out  1  one-cycle byte-start pulse to the master engine
- m_tx_data  out  8  byte to shift out; stable from m_start until m_done
- m_done  in  1  one-cycle byte-complete pulse from the engine
- m_rx_data  in  8  received byte; valid with m_done
- ss_n  out  1  slave select, active-low

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, ss_n=1, m_start=0, m_tx_data=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset mid-transaction drops the transaction with no rsp_valid, and ss_n goes high on the next edge.
- States: IDLE, SETUP_A, WAIT_A, GAP, SETUP_D, WAIT_D, TAIL. A single cycle counter is cleared on every state entry.
- IDLE:
  - ss_n=1.
  - If any req_valid: grant = the only requester valid, or on a tie !last_grant.
  - Pulse req_ready[grant]; latch wr, addr, wdata; update last_grant; go SETUP_A.
  - Requesters hold valid and fields until ready. valid may drop before ready without effect.
- SETUP_A:
  - ss_n=0.
  - After SETUP_CYCLES cycles: pulse m_start with m_tx_data={wr,5'b0,addr}; go WAIT_A.
- WAIT_A: ss_n=0. On m_done go GAP; m_rx_data is ignored.
- GAP: ss_n=1 for GAP_CYCLES cycles, then go SETUP_D.
- SETUP_D:
  - ss_n=0.
  - After SETUP_CYCLES cycles: pulse m_start with m_tx_data = wdata (write) or 8'h00 (read); go WAIT_D.
- WAIT_D: ss_n=0. On m_done:
  - Pulse rsp_valid[grant].
  - rsp_rdata = m_rx_data (read) or 8'h00 (write); rsp_err=0.
  - Go TAIL.
- TAIL: ss_n=1 for GAP_CYCLES cycles, then go IDLE. Back-to-back requests therefore always see the full SS-high gap.
- Latency: with acceptance at cycle t, ss_n falls at t+1 and the first m_start is at t+1+SETUP_CYCLES.
- m_done outside WAIT_A/WAIT_D is ignored.
- rsp_rdata and rsp_err hold their last value between pulses.
- req_valid arriving during busy is not sampled until IDLE.
- Counters are sized $clog2(max(param)+1); no wrap is possible.

Optional Feature:
- SPI_TIMEOUT_EN defined:
  - WAIT_A/WAIT_D count cycles without m_done.
  - At TIMEOUT_CYCLES: ss_n=1; pulse rsp_valid[grant] with rsp_err=1 and rsp_rdata=8'h00; go TAIL.
  - A late m_done is ignored.
- Not defined: WAIT states wait indefinitely; rsp_err is tied 0; TIMEOUT_CYCLES is unused.

Decomposition:
- Package spi_sched_pkg holds:
  - State enum.
  - RW bit position (7) and address field mask.
  - Read dummy byte 8'h00.
- One natural sub-module, rr_arb2: 2-way round-robin arbiter (req[1:0], last_grant in, grant/valid out), combinational plus the last_grant register.

Test Plan:
- Single write: req0 wr addr=1 wdata=8'h5A.
  - Bytes: m_tx_data 8'h81, then 8'h5A.
  - ss_n low-high-low-high with 50-cycle gaps; rsp_valid[0] with rsp_rdata=8'h00.
- Single read: req1 rd addr=2, engine returns m_rx_data=8'h3C on the second done.
  - Bytes: m_tx_data 8'h02, then 8'h00.
  - rsp_valid[1], rsp_rdata=8'h3C, rsp_err=0.
- Tie after reset, then both requesters held valid.
  - Grant order 0,1,0,1.
  - Each pair of transactions separated by at least GAP_CYCLES of ss_n high.
- Reset asserted in WAIT_D: ss_n=1 on the next edge, no rsp_valid, busy=0; a new request then completes normally.
- Spurious m_done in IDLE/GAP/TAIL: no state change and no response.
- SPI_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no m_done:
  - rsp_valid with rsp_err=1 at 16 cycles after m_start.
  - ss_n high; a late m_done is ignored.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg
// Shared types and constants for the SPI transaction scheduler.
//   sched_state_e : scheduler FSM states
//   RW_BIT        : bit position of the read/write flag in the address byte
//   ADDR_MASK     : mask of the register-address field in the address byte
//   READ_DUMMY    : byte shifted out during the data frame of a read
//   addr_byte()   : builds the address byte {rw, 5'b0, addr}
//   grant_onehot(): converts a requester index to a 2-bit one-hot vector
package spi_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP_A = 3'd1,
        ST_WAIT_A  = 3'd2,
        ST_GAP     = 3'd3,
        ST_SETUP_D = 3'd4,
        ST_WAIT_D  = 3'd5,
        ST_TAIL    = 3'd6
    } sched_state_e;

    localparam int         RW_BIT     = 7;
    localparam logic [7:0] ADDR_MASK  = 8'h03;
    localparam logic [7:0] READ_DUMMY = 8'h00;

    function automatic logic [7:0] addr_byte(input logic wr, input logic [1:0] addr);
        logic [7:0] b;
        b         = {6'b000000, addr} & ADDR_MASK;
        b[RW_BIT] = wr;
        return b;
    endfunction

    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_txn_sched_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. The grant is combinational from the request
// vector; the last_grant register advances only when the grant is taken.
// After reset last_grant is 1, so requester 0 wins the first tie.
// Ports:
//   clk    : system clock
//   reset  : synchronous active-low reset
//   req    : request vector, bit i = requester i
//   update : grant is being accepted this cycle; record it as last_grant
//   grant  : index of the winning requester (meaningful when valid)
//   valid  : at least one requester is asking
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant,
    output logic       valid
);

    logic last_grant_r;

    // Pick the sole requester, or the one not served last time on a tie.
    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_r;
            default: grant = 1'b0;
        endcase
    end

    assign valid = |req;

    // Remember who was served so the next tie goes the other way.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_r <= 1'b1;
        end else if (update) begin
            last_grant_r <= grant;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/spi_txn_sched.sv
// spi_txn_sched
// Two-requester register-access scheduler in front of a byte-level SPI master
// engine. Each access is two SS frames: address byte {rw,5'b0,addr}, an SS-high
// gap, then the data byte (write data, or a dummy byte for reads), followed by
// an SS-high tail so back-to-back accesses always see the full gap.
// Optional feature macro: SPI_TIMEOUT_EN -- adds an m_done watchdog of
// TIMEOUT_CYCLES in the WAIT states that completes the access with rsp_err=1.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   req_valid/wr/addr/wdata: per-requester request fields (packed, requester 1 high)
//   req_ready             : one-cycle accept pulse to the granted requester
//   rsp_valid             : one-cycle completion pulse to the owning requester
//   rsp_rdata, rsp_err    : read data / timeout flag, held between pulses
//   busy                  : high whenever the scheduler is not IDLE
//   m_start, m_tx_data    : byte-start pulse and byte to the master engine
//   m_done, m_rx_data     : byte-complete pulse and received byte from the engine
//   ss_n                  : active-low slave select
module spi_txn_sched
    import spi_sched_pkg::*;
#(
    parameter int SETUP_CYCLES   = 4,
    parameter int GAP_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_wr,
    input  logic [3:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        m_start,
    output logic [7:0]  m_tx_data,
    input  logic        m_done,
    input  logic [7:0]  m_rx_data,
    output logic        ss_n
);

    localparam int CNT_MAX_SG = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX    = (TIMEOUT_CYCLES > CNT_MAX_SG) ? TIMEOUT_CYCLES : CNT_MAX_SG;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SETUP_CYCLES);
    // ss_n only follows the state one cycle later, so the first SETUP_D cycle
    // still shows ss_n high; leaving GAP one cycle early keeps the SS-high
    // gap between frames at exactly GAP_CYCLES. The same end point in TAIL
    // plus the IDLE/accept cycles gives at least GAP_CYCLES between accesses.
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYCLES - 2);
`ifdef SPI_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    sched_state_e     state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             grant_r;
    logic             wr_r;
    logic [1:0]       addr_r;
    logic [7:0]       wdata_r;

    logic             grant_s;
    logic             arb_valid_s;
    logic             accept_s;
    logic             sel_wr_s;
    logic [1:0]       sel_addr_s;
    logic [7:0]       sel_wdata_s;

    assign accept_s = (state_r == ST_IDLE) && arb_valid_s;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .update (accept_s),
        .grant  (grant_s),
        .valid  (arb_valid_s)
    );

    // Select the request fields of the requester the arbiter picked.
    always_comb begin
        sel_wr_s    = 1'b0;
        sel_addr_s  = 2'b00;
        sel_wdata_s = 8'h00;
        if (grant_s) begin
            sel_wr_s    = req_wr[1];
            sel_addr_s  = req_addr[3:2];
            sel_wdata_s = req_wdata[15:8];
        end else begin
            sel_wr_s    = req_wr[0];
            sel_addr_s  = req_addr[1:0];
            sel_wdata_s = req_wdata[7:0];
        end
    end

    // Scheduler FSM: sequences both SS frames and drives all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            grant_r   <= 1'b0;
            wr_r      <= 1'b0;
            addr_r    <= 2'b00;
            wdata_r   <= 8'h00;
            ss_n      <= 1'b1;
            m_start   <= 1'b0;
            m_tx_data <= 8'h00;
            req_ready <= 2'b00;
            rsp_valid <= 2'b00;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            req_ready <= 2'b00;
            rsp_valid <= 2'b00;
            m_start   <= 1'b0;
            // Saturating count; every state change below clears it.
            if (cnt_r != CNT_TOP) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end

            case (state_r)
                ST_IDLE: begin
                    ss_n <= 1'b1;
                    if (arb_valid_s) begin
                        req_ready <= grant_onehot(grant_s);
                        grant_r   <= grant_s;
                        wr_r      <= sel_wr_s;
                        addr_r    <= sel_addr_s;
                        wdata_r   <= sel_wdata_s;
                        busy      <= 1'b1;
                        state_r   <= ST_SETUP_A;
                        cnt_r     <= CNT_ZERO;
                    end else begin
                        busy      <= 1'b0;
                    end
                end

                ST_SETUP_A: begin
                    ss_n <= 1'b0;
                    if (cnt_r == SETUP_END) begin
                        m_start   <= 1'b1;
                        m_tx_data <= addr_byte(wr_r, addr_r);
                        state_r   <= ST_WAIT_A;
                        cnt_r     <= CNT_ZERO;
                    end else begin
                        state_r   <= ST_SETUP_A;
                    end
                end

                ST_WAIT_A: begin
                    ss_n <= 1'b0;
                    // The byte received during the address frame carries no data.
                    if (m_done) begin
                        ss_n    <= 1'b1;
                        state_r <= ST_GAP;
                        cnt_r   <= CNT_ZERO;
                    end
`ifdef SPI_TIMEOUT_EN
                    else if (cnt_r == TIMEOUT_END) begin
                        ss_n      <= 1'b1;
                        rsp_valid <= grant_onehot(grant_r);
                        rsp_rdata <= 8'h00;
                        rsp_err   <= 1'b1;
                        state_r   <= ST_TAIL;
                        cnt_r     <= CNT_ZERO;
                    end
`endif
                    else begin
                        state_r <= ST_WAIT_A;
                    end
                end

                ST_GAP: begin
                    ss_n <= 1'b1;
                    if (cnt_r == GAP_END) begin
                        state_r <= ST_SETUP_D;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= ST_GAP;
                    end
                end

                ST_SETUP_D: begin
                    ss_n <= 1'b0;
                    if (cnt_r == SETUP_END) begin
                        m_start   <= 1'b1;
                        m_tx_data <= wr_r ? wdata_r : READ_DUMMY;
                        state_r   <= ST_WAIT_D;
                        cnt_r     <= CNT_ZERO;
                    end else begin
                        state_r   <= ST_SETUP_D;
                    end
                end

                ST_WAIT_D: begin
                    ss_n <= 1'b0;
                    if (m_done) begin
                        ss_n      <= 1'b1;
                        rsp_valid <= grant_onehot(grant_r);
                        rsp_rdata <= wr_r ? 8'h00 : m_rx_data;
                        rsp_err   <= 1'b0;
                        state_r   <= ST_TAIL;
                        cnt_r     <= CNT_ZERO;
                    end
`ifdef SPI_TIMEOUT_EN
                    else if (cnt_r == TIMEOUT_END) begin
                        ss_n      <= 1'b1;
                        rsp_valid <= grant_onehot(grant_r);
                        rsp_rdata <= 8'h00;
                        rsp_err   <= 1'b1;
                        state_r   <= ST_TAIL;
                        cnt_r     <= CNT_ZERO;
                    end
`endif
                    else begin
                        state_r <= ST_WAIT_D;
                    end
                end

                ST_TAIL: begin
                    ss_n <= 1'b1;
                    if (cnt_r == GAP_END) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= ST_TAIL;
                    end
                end

                default: begin
                    ss_n    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_sched.sv
// tb_spi_txn_sched
// Scoreboard bench for spi_txn_sched: requests are queued with their expected
// grant, bytes and response; a monitor pops and compares as the DUT acts.
// A small engine model answers each m_start with m_done after a fixed latency.
// With SPI_TIMEOUT_EN defined an extra watchdog scenario is run.
module tb_spi_txn_sched;

    localparam int SETUP   = 4;
    localparam int GAP     = 50;
    localparam int TIMEOUT = 16;
    localparam int ENG_LAT = 8;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
    } req_t;

    typedef struct {
        int         id;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_wr = 2'b00;
    logic [3:0]  req_addr = 4'h0;
    logic [15:0] req_wdata = 16'h0000;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        m_start;
    logic [7:0]  m_tx_data;
    logic        m_done = 1'b0;
    logic [7:0]  m_rx_data = 8'h00;
    logic        ss_n;

    int n_cmp = 0;
    int n_err = 0;

    req_t       pend0[$];
    req_t       pend1[$];
    int         exp_grant[$];
    logic [7:0] exp_tx[$];
    rsp_t       exp_rsp[$];
    logic [7:0] eng_rx[$];

    logic eng_en = 1'b1;
    logic spur_en = 1'b0;
    logic spur_now = 1'b0;

    int   cyc = 0;
    int   t_acc = 0;
    int   t_ms = 0;
    int   t_rsp = 0;
    int   ms_cnt = 0;
    int   rise_cyc = 0;
    logic rise_ok = 1'b0;
    logic prev_ss = 1'b1;
    logic ss_at_rsp = 1'b0;

    spi_txn_sched #(
        .SETUP_CYCLES   (SETUP),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .m_start   (m_start),
        .m_tx_data (m_tx_data),
        .m_done    (m_done),
        .m_rx_data (m_rx_data),
        .ss_n      (ss_n)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Queue one request and everything the DUT is expected to do for it.
    task automatic queue_txn(input int id, input logic wr, input logic [1:0] addr,
                             input logic [7:0] wdata, input logic [7:0] rx);
        req_t r;
        rsp_t e;
        r.wr = wr; r.addr = addr; r.wdata = wdata;
        if (id == 0) pend0.push_back(r); else pend1.push_back(r);
        exp_grant.push_back(id);
        exp_tx.push_back({wr, 5'b00000, addr});
        exp_tx.push_back(wr ? wdata : 8'h00);
        eng_rx.push_back(8'hA5);
        eng_rx.push_back(wr ? 8'hEE : rx);
        e.id = id; e.rdata = wr ? 8'h00 : rx; e.err = 1'b0;
        exp_rsp.push_back(e);
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while (!(exp_rsp.size() == 0 && pend0.size() == 0 && pend1.size() == 0 &&
                 req_valid == 2'b00 && !busy) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        check_val("quiet_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic pulse_spur();
        spur_now = 1'b1;
        @(posedge clk); #2;
        spur_now = 1'b0;
    endtask

    // Requesters: hold valid and fields until req_ready, then load the next one.
    req_t d0, d1;
    always @(negedge clk) begin
        if (req_ready[0]) req_valid[0] = 1'b0;
        if (req_ready[1]) req_valid[1] = 1'b0;
        if (!req_valid[0] && pend0.size() > 0) begin
            d0 = pend0.pop_front();
            req_valid[0] = 1'b1; req_wr[0] = d0.wr;
            req_addr[1:0] = d0.addr; req_wdata[7:0] = d0.wdata;
        end
        if (!req_valid[1] && pend1.size() > 0) begin
            d1 = pend1.pop_front();
            req_valid[1] = 1'b1; req_wr[1] = d1.wr;
            req_addr[3:2] = d1.addr; req_wdata[15:8] = d1.wdata;
        end
    end

    // Engine model: m_done ENG_LAT cycles after m_start, plus optional spurious dones.
    int eng_cnt = 0;
    int spur_cnt = 0;
    always @(negedge clk) begin
        m_done = 1'b0;
        if (!reset) begin
            eng_cnt = 0;
            spur_cnt = 0;
            eng_rx.delete();
        end else begin
            if (m_start && eng_en) begin
                eng_cnt = ENG_LAT;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    m_done = 1'b1;
                    m_rx_data = (eng_rx.size() > 0) ? eng_rx.pop_front() : 8'h00;
                    if (spur_en) spur_cnt = 10;
                end
            end
            if (spur_cnt > 0) begin
                spur_cnt--;
                if (spur_cnt == 0) begin
                    m_done = 1'b1;
                    m_rx_data = 8'h77;
                end
            end
            if (spur_now) begin
                m_done = 1'b1;
                m_rx_data = 8'h66;
            end
        end
    end

    // Monitor: grants, ss_n timing, bytes and responses against the scoreboard.
    int   g_exp;
    rsp_t r_exp;
    always @(negedge clk) begin
        cyc++;
        if (req_ready != 2'b00) begin
            if (exp_grant.size() == 0) begin
                check_val("ready_unexpected", 32'(req_ready), 32'd0);
            end else begin
                g_exp = exp_grant.pop_front();
                check_val("grant", 32'(req_ready), (g_exp == 1) ? 32'd2 : 32'd1);
            end
            t_acc = cyc;
            ms_cnt = 0;
        end
        if (!reset) begin
            rise_ok = 1'b0;
            prev_ss = 1'b1;
        end else begin
            if (prev_ss && !ss_n) begin
                if (ms_cnt == 0) check_val("ss_fall_latency", 32'(cyc - t_acc), 32'd1);
                if (rise_ok) begin
                    if (ms_cnt == 1) check_val("frame_gap", 32'(cyc - rise_cyc), 32'(GAP));
                    else check_val("txn_gap_ge", 32'((cyc - rise_cyc) >= GAP), 32'd1);
                end
            end
            if (!prev_ss && ss_n) begin
                rise_cyc = cyc;
                rise_ok = 1'b1;
            end
            prev_ss = ss_n;
        end
        if (m_start) begin
            t_ms = cyc;
            check_val("ss_low_at_start", 32'(ss_n), 32'd0);
            if (ms_cnt == 0) check_val("start_latency", 32'(cyc - t_acc), 32'(1 + SETUP));
            ms_cnt++;
            if (exp_tx.size() == 0) check_val("start_unexpected", 32'd1, 32'd0);
            else check_val("tx_byte", 32'(m_tx_data), 32'(exp_tx.pop_front()));
        end
        if (rsp_valid != 2'b00) begin
            t_rsp = cyc;
            ss_at_rsp = ss_n;
            if (exp_rsp.size() == 0) begin
                check_val("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                r_exp = exp_rsp.pop_front();
                check_val("rsp_owner", 32'(rsp_valid), (r_exp.id == 1) ? 32'd2 : 32'd1);
                check_val("rsp_rdata", 32'(rsp_rdata), 32'(r_exp.rdata));
                check_val("rsp_err", 32'(rsp_err), 32'(r_exp.err));
            end
        end
    end

    initial begin
        int n;
`ifdef SPI_TIMEOUT_EN
        req_t tr;
        rsp_t te;
`endif
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_ss_n", 32'(ss_n), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_val("rst_m_start", 32'(m_start), 32'd0);
        check_val("rst_m_tx_data", 32'(m_tx_data), 32'd0);
        reset = 1'b1;

        // Tie right after reset, both held valid: grants 0,1,0,1.
        queue_txn(0, 1'b1, 2'd1, 8'h5A, 8'h00);
        queue_txn(1, 1'b0, 2'd2, 8'h00, 8'h3C);
        queue_txn(0, 1'b0, 2'd3, 8'h00, 8'hC3);
        queue_txn(1, 1'b1, 2'd0, 8'h81, 8'h00);
        wait_quiet(3000);

        // Single accesses with spurious m_done pulses inside GAP and TAIL.
        spur_en = 1'b1;
        queue_txn(0, 1'b1, 2'd2, 8'hA7, 8'h00);
        wait_quiet(1000);
        queue_txn(1, 1'b0, 2'd1, 8'h00, 8'h5E);
        wait_quiet(1000);
        spur_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_val("rdata_hold", 32'(rsp_rdata), 32'h5E);

        // Spurious m_done while idle.
        pulse_spur();
        repeat (5) @(posedge clk);
        #2;
        check_val("idle_spur_busy", 32'(busy), 32'd0);
        check_val("idle_spur_ss_n", 32'(ss_n), 32'd1);

        // Reset during WAIT_D drops the access.
        queue_txn(1, 1'b0, 2'd3, 8'h00, 8'h99);
        n = 0;
        while (!(exp_grant.size() == 0 && ms_cnt == 2) && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        check_val("reach_wait_d", 32'(n < 1000), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        check_val("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        exp_tx.delete();
        exp_rsp.delete();
        exp_grant.delete();
        @(posedge clk);
        #2;
        reset = 1'b1;
        check_val("midrst_ss_n", 32'(ss_n), 32'd1);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (20) @(posedge clk);
        #2;
        check_val("postrst_idle", 32'(busy), 32'd0);
        queue_txn(1, 1'b1, 2'd2, 8'h42, 8'h00);
        wait_quiet(1000);

`ifdef SPI_TIMEOUT_EN
        // Engine stays silent: watchdog completes the access with rsp_err.
        eng_en = 1'b0;
        tr.wr = 1'b0; tr.addr = 2'd1; tr.wdata = 8'h00;
        pend0.push_back(tr);
        exp_grant.push_back(0);
        exp_tx.push_back(8'h01);
        te.id = 0; te.rdata = 8'h00; te.err = 1'b1;
        exp_rsp.push_back(te);
        n = 0;
        while (exp_rsp.size() != 0 && n < 500) begin
            @(posedge clk); #2;
            n++;
        end
        check_val("timeout_seen", 32'(n < 500), 32'd1);
        check_val("timeout_latency", 32'(t_rsp - t_ms), 32'(TIMEOUT));
        check_val("timeout_ss_n", 32'(ss_at_rsp), 32'd1);
        pulse_spur();
        wait_quiet(500);
        check_val("timeout_err_hold", 32'(rsp_err), 32'd1);
        eng_en = 1'b1;
`endif

        check_val("left_tx", 32'(exp_tx.size()), 32'd0);
        check_val("left_rsp", 32'(exp_rsp.size()), 32'd0);
        check_val("left_grant", 32'(exp_grant.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
